// File: rtl/puf_keygen_ctrl.sv
// PUF key regeneration sequencer: fetches an RO-PUF response, runs BCH error correction,
// weighs the error vector CHUNK bits per cycle and retries on excess errors or timeout.
module puf_keygen_ctrl #(
    parameter int unsigned N         = 264,
    parameter int unsigned CHUNK     = 8,
    parameter int unsigned MAX_ERR   = 24,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [N-1:0] helper,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [N-1:0] key,
    output logic [8:0]   err_weight,
    output logic [1:0]   attempts,
    output logic         puf_start,
    input  logic         puf_done,
    input  logic [N-1:0] puf_response,
    output logic         ec_start,
    output logic [N-1:0] ec_RplusC,
    output logic [N-1:0] ec_response,
    input  logic         ec_ready,
    input  logic [N-1:0] ec_corrected,
    input  logic [N-1:0] ec_err_found
);

    localparam int unsigned NCHUNK = N / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT);
    localparam int unsigned WW     = 9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUF_REQ,
        S_PUF_WAIT,
        S_EC_START,
        S_EC_WAIT,
        S_WEIGH,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [CW-1:0]   r_cnt;
    logic [WW-1:0]   r_sum;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    r_shadow;
    logic            r_ready_q;

    logic            w_ready_rise;
    logic            w_timeout;
    logic            w_last_try;
    logic            w_weigh_last;
    logic [WW-1:0]   w_chunk_wt;

    // Only a fresh low-to-high transition counts; a level left high from the previous job is stale.
    assign w_ready_rise = ec_ready & ~r_ready_q;
    assign w_timeout    = (r_timer == TW'(TIMEOUT - 1));
    assign w_last_try   = (attempts == 2'(MAX_RETRY));
    assign w_weigh_last = (r_cnt == CW'(NCHUNK - 1));

    // Popcount of the chunk currently at the bottom of the error shift register.
    always_comb begin
        w_chunk_wt = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            w_chunk_wt = w_chunk_wt + WW'(r_shift[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_shift     <= '0;
            r_shadow    <= '0;
            r_ready_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            key         <= '0;
            err_weight  <= '0;
            attempts    <= '0;
            puf_start   <= 1'b0;
            ec_start    <= 1'b0;
            ec_RplusC   <= '0;
            ec_response <= '0;
        end else begin
            puf_start <= 1'b0;
            ec_start  <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;

            case (r_state)
                // busy still high here means this is the done/fail cycle; drop it before taking a new req.
                S_IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (req) begin
                        ec_RplusC <= helper;
                        attempts  <= '0;
                        busy      <= 1'b1;
                        puf_start <= 1'b1;
                        r_state   <= S_PUF_REQ;
                    end
                end

                S_PUF_REQ: begin
                    r_timer <= '0;
                    r_state <= S_PUF_WAIT;
                end

                S_PUF_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (puf_done) begin
                        ec_response <= puf_response;
                        ec_start    <= 1'b1;
                        r_state     <= S_EC_START;
                    end else if (w_timeout) begin
                        if (w_last_try) begin
                            r_state <= S_FAIL;
                        end else begin
                            attempts  <= attempts + 2'd1;
                            puf_start <= 1'b1;
                            r_state   <= S_PUF_REQ;
                        end
                    end
                end

                S_EC_START: begin
                    r_ready_q <= ec_ready;
                    r_timer   <= '0;
                    r_state   <= S_EC_WAIT;
                end

                S_EC_WAIT: begin
                    r_ready_q <= ec_ready;
                    r_timer   <= r_timer + TW'(1);
                    if (w_ready_rise) begin
                        r_shadow <= ec_corrected;
                        r_shift  <= ec_err_found;
                        r_sum    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_WEIGH;
                    end else if (w_timeout) begin
                        if (w_last_try) begin
                            r_state <= S_FAIL;
                        end else begin
                            attempts  <= attempts + 2'd1;
                            puf_start <= 1'b1;
                            r_state   <= S_PUF_REQ;
                        end
                    end
                end

                S_WEIGH: begin
                    r_sum   <= r_sum + w_chunk_wt;
                    r_shift <= r_shift >> CHUNK;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_weigh_last) begin
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    err_weight <= r_sum;
                    if (r_sum <= WW'(MAX_ERR)) begin
                        key     <= r_shadow;
                        r_state <= S_DONE;
                    end else if (w_last_try) begin
                        r_state <= S_FAIL;
                    end else begin
                        attempts  <= attempts + 2'd1;
                        puf_start <= 1'b1;
                        r_state   <= S_PUF_REQ;
                    end
                end

                S_DONE: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end

                S_FAIL: begin
                    fail    <= 1'b1;
                    key     <= '0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_keygen_ctrl.sv
// Directed bench for puf_keygen_ctrl: inputs driven and outputs sampled on the falling edge,
// expected values and cycle positions worked out by hand from the controller's latency.
`timescale 1ns/1ps
module tb_puf_keygen_ctrl;

    localparam int unsigned N = 264;

    localparam logic [N-1:0] H1  = {33{8'h3C}};
    localparam logic [N-1:0] R1  = {33{8'hA7}};
    localparam logic [N-1:0] C1  = {11{24'h5AC319}};
    localparam logic [N-1:0] C2  = {33{8'hC2}};
    localparam logic [N-1:0] C4  = {33{8'h4D}};
    localparam logic [N-1:0] C6  = {11{24'h0F1E2D}};
    localparam logic [N-1:0] C8  = {33{8'h69}};
    localparam logic [N-1:0] BAD = {33{8'hEE}};
    localparam logic [N-1:0] ERR24 = {8'hFF, 200'd0, 8'h0F, 8'h0F, 8'h81, 8'h11, 8'h24, 8'h80, 8'h01};
    localparam logic [N-1:0] ERR25 = {8'hFF, 200'd0, 8'h0F, 8'h0F, 8'h81, 8'h11, 8'h24, 8'h80, 8'h03};
    localparam logic [N-1:0] ERR5  = {8'h01, 232'd0, 8'h10, 8'h0B, 8'h00};

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [N-1:0] helper;
    logic         busy;
    logic         done;
    logic         fail;
    logic [N-1:0] key;
    logic [8:0]   err_weight;
    logic [1:0]   attempts;
    logic         puf_start;
    logic         puf_done;
    logic [N-1:0] puf_response;
    logic         ec_start;
    logic [N-1:0] ec_RplusC;
    logic [N-1:0] ec_response;
    logic         ec_ready;
    logic [N-1:0] ec_corrected;
    logic [N-1:0] ec_err_found;

    int checks = 0;
    int errors = 0;

    puf_keygen_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .helper       (helper),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .key          (key),
        .err_weight   (err_weight),
        .attempts     (attempts),
        .puf_start    (puf_start),
        .puf_done     (puf_done),
        .puf_response (puf_response),
        .ec_start     (ec_start),
        .ec_RplusC    (ec_RplusC),
        .ec_response  (ec_response),
        .ec_ready     (ec_ready),
        .ec_corrected (ec_corrected),
        .ec_err_found (ec_err_found)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns in the cycle where puf_start should be visible.
    task automatic start_req(input logic [N-1:0] h);
        req = 1'b1; helper = h;
        tick(1);
        req = 1'b0;
    endtask

    // Returns in the cycle where ec_start should be visible.
    task automatic puf_reply(input logic [N-1:0] r);
        puf_done = 1'b1; puf_response = r;
        tick(1);
        puf_done = 1'b0;
    endtask

    // Rising ec_ready with data for one cycle; returns one cycle after the rise.
    task automatic ec_reply(input logic [N-1:0] c, input logic [N-1:0] e);
        ec_ready = 1'b1; ec_corrected = c; ec_err_found = e;
        tick(1);
        ec_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if ({done, fail, puf_start, ec_start} !== 4'b0000) begin errors++; $display("FAIL reset pulses: got %b want 0000", {done, fail, puf_start, ec_start}); end
        checks++; if (key !== '0) begin errors++; $display("FAIL reset key: got %h want 0", key); end
        checks++; if ({err_weight, attempts} !== 11'd0) begin errors++; $display("FAIL reset weight/attempts: got %0d/%0d want 0/0", err_weight, attempts); end
        rst = 1'b0;
        tick(2);
        checks++; if ({busy, puf_start} !== 2'b00) begin errors++; $display("FAIL post-reset idle: got busy=%b puf_start=%b want 0 0", busy, puf_start); end
    endtask

    task automatic test_clean_run();
        start_req(H1);
        checks++; if ({busy, puf_start} !== 2'b11) begin errors++; $display("FAIL clean accept: got busy=%b puf_start=%b want 1 1", busy, puf_start); end
        tick(1);
        checks++; if (puf_start !== 1'b0) begin errors++; $display("FAIL clean puf_start width: got %b want 0", puf_start); end
        tick(1);
        puf_reply(R1);
        checks++; if (ec_start !== 1'b1) begin errors++; $display("FAIL clean ec_start: got %b want 1", ec_start); end
        checks++; if (ec_RplusC !== H1 || ec_response !== R1) begin errors++; $display("FAIL clean ec operands: got %h / %h want %h / %h", ec_RplusC, ec_response, H1, R1); end
        tick(20);
        checks++; if (ec_response !== R1 || busy !== 1'b1) begin errors++; $display("FAIL clean stable: got resp=%h busy=%b want %h 1", ec_response, busy, R1); end
        ec_reply(C1, '0);
        tick(34);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean early done: got %b want 0", done); end
        tick(1);
        checks++; if ({done, fail, busy} !== 3'b101) begin errors++; $display("FAIL clean done: got done=%b fail=%b busy=%b want 1 0 1", done, fail, busy); end
        checks++; if (key !== C1) begin errors++; $display("FAIL clean key: got %h want %h", key, C1); end
        checks++; if (err_weight !== 9'd0 || attempts !== 2'd0) begin errors++; $display("FAIL clean weight/attempts: got %0d/%0d want 0/0", err_weight, attempts); end
        tick(1);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL clean release: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_weight_boundary();
        start_req({33{8'h11}});
        tick(2);
        puf_reply({33{8'h22}});
        tick(1);
        ec_reply(C2, ERR24);
        tick(35);
        checks++; if (done !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL w24 done: got done=%b fail=%b want 1 0", done, fail); end
        checks++; if (err_weight !== 9'd24 || key !== C2) begin errors++; $display("FAIL w24 result: got w=%0d key=%h want 24 %h", err_weight, key, C2); end
        tick(1);

        start_req({33{8'h33}});
        for (int a = 0; a < 4; a++) begin
            checks++; if (puf_start !== 1'b1 || attempts !== 2'(a)) begin errors++; $display("FAIL w25 attempt %0d: got puf_start=%b attempts=%0d want 1 %0d", a, puf_start, attempts, a); end
            tick(2);
            puf_reply({33{8'h44}} ^ N'(a));
            tick(1);
            ec_reply(BAD, ERR25);
            tick(34);
        end
        checks++; if (puf_start !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL w25 no fifth try: got puf_start=%b fail=%b want 0 0", puf_start, fail); end
        tick(1);
        checks++; if ({fail, done, busy} !== 3'b101) begin errors++; $display("FAIL w25 fail pulse: got fail=%b done=%b busy=%b want 1 0 1", fail, done, busy); end
        checks++; if (key !== '0 || attempts !== 2'd3 || err_weight !== 9'd25) begin errors++; $display("FAIL w25 result: got key=%h attempts=%0d w=%0d want 0 3 25", key, attempts, err_weight); end
        tick(1);
        checks++; if ({fail, busy} !== 2'b00) begin errors++; $display("FAIL w25 release: got fail=%b busy=%b want 0 0", fail, busy); end
    endtask

    task automatic test_stale_ready();
        start_req({33{8'h55}});
        tick(2);
        ec_ready = 1'b1; ec_corrected = BAD; ec_err_found = '0;
        puf_reply({33{8'h66}});
        checks++; if (ec_start !== 1'b1) begin errors++; $display("FAIL stale ec_start: got %b want 1", ec_start); end
        tick(3);
        ec_ready = 1'b0;
        tick(10);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stale ignored: got busy=%b done=%b want 1 0", busy, done); end
        ec_reply(C4, ERR5);
        tick(35);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stale done timing: got %b want 1", done); end
        checks++; if (key !== C4 || err_weight !== 9'd5 || attempts !== 2'd0) begin errors++; $display("FAIL stale result: got key=%h w=%0d att=%0d want %h 5 0", key, err_weight, attempts, C4); end
        tick(1);
    endtask

    task automatic test_timeout();
        int pulses;
        int last_pulse;
        int fail_at;
        pulses = 0; last_pulse = -1; fail_at = -1;
        start_req({33{8'h77}});
        for (int c = 1; c <= 16500; c++) begin
            if (puf_start === 1'b1) begin pulses++; last_pulse = c; end
            if (fail === 1'b1) begin fail_at = c; break; end
            tick(1);
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL timeout pulses: got %0d want 4", pulses); end
        checks++; if (last_pulse != 12292) begin errors++; $display("FAIL timeout last puf_start: got cycle %0d want 12292", last_pulse); end
        checks++; if (fail_at != 16390) begin errors++; $display("FAIL timeout fail cycle: got %0d want 16390", fail_at); end
        checks++; if (attempts !== 2'd3 || key !== '0) begin errors++; $display("FAIL timeout result: got att=%0d key=%h want 3 0", attempts, key); end
        tick(1);
    endtask

    task automatic test_back_to_back();
        start_req({33{8'h88}});
        req = 1'b1; helper = {33{8'h99}};
        tick(2);
        checks++; if (puf_start !== 1'b0 || ec_RplusC !== {33{8'h88}}) begin errors++; $display("FAIL b2b busy req: got puf_start=%b helper=%h want 0 %h", puf_start, ec_RplusC, {33{8'h88}}); end
        req = 1'b0;
        puf_reply({33{8'hAA}});
        tick(1);
        ec_reply(C6, ERR5);
        tick(35);
        checks++; if (done !== 1'b1 || key !== C6) begin errors++; $display("FAIL b2b done: got done=%b key=%h want 1 %h", done, key, C6); end
        req = 1'b1; helper = {33{8'hBB}};
        tick(1);
        checks++; if ({puf_start, busy} !== 2'b00) begin errors++; $display("FAIL b2b coincident req: got puf_start=%b busy=%b want 0 0", puf_start, busy); end
        tick(1);
        req = 1'b0;
        checks++; if ({puf_start, busy} !== 2'b11 || ec_RplusC !== {33{8'hBB}}) begin errors++; $display("FAIL b2b next req: got puf_start=%b busy=%b helper=%h want 1 1 %h", puf_start, busy, ec_RplusC, {33{8'hBB}}); end
    endtask

    // Continues the request left in flight by test_back_to_back.
    task automatic test_reset_mid_run();
        tick(2);
        puf_reply({33{8'hCC}});
        tick(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst pre busy: got %b want 1", busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if ({busy, ec_start, done, fail} !== 4'b0000) begin errors++; $display("FAIL midrst outputs: got %b want 0000", {busy, ec_start, done, fail}); end
        checks++; if (key !== '0 || attempts !== 2'd0 || err_weight !== 9'd0) begin errors++; $display("FAIL midrst state: got key=%h att=%0d w=%0d want 0 0 0", key, attempts, err_weight); end
        tick(1);
        start_req({33{8'hDD}});
        checks++; if (puf_start !== 1'b1) begin errors++; $display("FAIL midrst restart: got %b want 1", puf_start); end
        tick(2);
        puf_reply({33{8'hEF}});
        checks++; if (ec_start !== 1'b1 || ec_response !== {33{8'hEF}}) begin errors++; $display("FAIL midrst ec_start: got %b resp=%h want 1 %h", ec_start, ec_response, {33{8'hEF}}); end
        tick(1);
        ec_reply(C8, ERR24);
        tick(35);
        checks++; if (done !== 1'b1 || key !== C8 || err_weight !== 9'd24) begin errors++; $display("FAIL midrst done: got done=%b key=%h w=%0d want 1 %h 24", done, key, err_weight, C8); end
        tick(1);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; helper = '0;
        puf_done = 1'b0; puf_response = '0;
        ec_ready = 1'b0; ec_corrected = '0; ec_err_found = '0;
        test_reset();
        test_clean_run();
        test_weight_boundary();
        test_stale_ready();
        test_timeout();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
